// File: rtl/mpc_types_pkg.sv
// Shared request-op encodings and write-buffer id type used by the HTU front end.
// Ops that are neither loads nor stores still need a free wbuf entry to be eligible.
package mpc_types_pkg;

   localparam int WbufNumDef   = 8;
   localparam int WbufWidthDef = $clog2(WbufNumDef);

   typedef logic [WbufWidthDef-1:0] wbuf_id_t;

   typedef enum logic [2:0] {
      OP_LD    = 3'd0,
      OP_ST    = 3'd1,
      OP_LR    = 3'd2,
      OP_SC    = 3'd3,
      OP_PF    = 3'd4,
      OP_FLUSH = 3'd5
   } op_e;

   function automatic logic is_load(input logic [2:0] op);
      return (op == OP_LD) || (op == OP_LR) || (op == OP_PF);
   endfunction

   function automatic logic is_store(input logic [2:0] op);
      return (op == OP_ST) || (op == OP_SC);
   endfunction

endpackage

// File: rtl/htu_wbuf_freelist.sv
// Write-buffer free list: bitmap of free ids, lowest-free finder and a free counter.
// Allocation reads the registered bitmap, so an id freed this cycle is handed out next cycle at the earliest.
module htu_wbuf_freelist #(
   parameter int WbufNum   = 8,
   parameter int WbufWidth = $clog2(WbufNum)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_req,
   output logic [WbufWidth-1:0] alloc_id,
   output logic                 empty,
   input  logic                 free_valid,
   input  logic [WbufWidth-1:0] free_id,
   output logic [WbufWidth:0]   cnt
);

   logic [WbufNum-1:0] bitmap_q;
   logic [WbufNum-1:0] bitmap_d;
   logic [WbufWidth:0] cnt_q;
   logic               do_alloc;
   logic               do_free;
   logic               double_free;

   // Scan high to low so the last hit is the lowest set bit.
   always_comb begin
      alloc_id = '0;
      for (int i = WbufNum - 1; i >= 0; i--) begin
         if (bitmap_q[i]) alloc_id = WbufWidth'(i);
      end
   end

   assign empty       = ~|bitmap_q;
   assign do_alloc    = alloc_req & ~empty;
   assign double_free = free_valid & bitmap_q[free_id];
   assign do_free     = free_valid & ~bitmap_q[free_id];

   always_comb begin
      bitmap_d = bitmap_q;
      if (do_alloc) bitmap_d[alloc_id] = 1'b0;
      if (do_free)  bitmap_d[free_id]  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bitmap_q <= '1;
         cnt_q    <= (WbufWidth + 1)'(WbufNum);
      end else begin
         bitmap_q <= bitmap_d;
         case ({do_free, do_alloc})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         assert (!double_free)
            else $error("htu_wbuf_freelist: double free of wbuf id %0d", free_id);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/htu_req_arb.sv
// Round-robin request arbiter feeding the HTU tag pipeline; grants allocate a wbuf id for stores.
// valid/ready: a transfer happens on any edge where both valid and ready are high; valid never depends on ready.
module htu_req_arb
   import mpc_types_pkg::*;
#(
   parameter int NumCh     = 3,
   parameter int WbufNum   = 8,
   parameter int WbufWidth = $clog2(WbufNum),
   parameter int AddrWidth = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NumCh-1:0]                    ch_req_valid,
   output logic [NumCh-1:0]                    ch_req_ready,
   input  logic [NumCh-1:0][2:0]               ch_req_op,
   input  logic [NumCh-1:0][AddrWidth-1:0]     ch_req_addr,
   output logic                                d_bank_req_valid,
   input  logic                                d_bank_req_ready,
   output logic [2:0]                          d_bank_req_op,
   output logic [AddrWidth-1:0]                d_bank_req_addr,
   output logic [NumCh-1:0]                    d_bank_req_channel_1hot_id,
   output logic [WbufWidth-1:0]                d_bank_req_wbuf_id,
   input  logic                                wbuf_free_valid,
   input  logic [WbufWidth-1:0]                wbuf_free_id,
   output logic [WbufWidth:0]                  wbuf_free_cnt
);

   localparam int PtrW = (NumCh > 1) ? $clog2(NumCh) : 1;

   logic [PtrW-1:0]      ptr_q;
   logic [NumCh-1:0]     eligible;
   logic [NumCh-1:0]     grant;
   logic [PtrW-1:0]      grant_idx;
   logic                 load_en;
   logic                 fire;
   logic [2:0]           sel_op;
   logic [AddrWidth-1:0] sel_addr;
   logic                 sel_store;
   logic                 alloc_req;
   logic [WbufWidth-1:0] alloc_id;
   logic                 wbuf_empty;

   assign load_en = ~d_bank_req_valid | d_bank_req_ready;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NumCh; i++) begin
         eligible[i] = ch_req_valid[i] & (is_load(ch_req_op[i]) | ~wbuf_empty);
      end
   end

   // First eligible channel at or after the pointer, wrapping modulo NumCh.
   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < NumCh; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NumCh) idx = idx - NumCh;
         if ((grant == '0) && eligible[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PtrW'(idx);
         end
      end
   end

   assign fire         = ~rst & load_en & (|grant);
   assign ch_req_ready = fire ? grant : '0;

   assign sel_op    = ch_req_op[grant_idx];
   assign sel_addr  = ch_req_addr[grant_idx];
   assign sel_store = is_store(sel_op);
   assign alloc_req = fire & sel_store;

   htu_wbuf_freelist #(
      .WbufNum   (WbufNum),
      .WbufWidth (WbufWidth)
   ) u_freelist (
      .clk        (clk),
      .rst        (rst),
      .alloc_req  (alloc_req),
      .alloc_id   (alloc_id),
      .empty      (wbuf_empty),
      .free_valid (wbuf_free_valid),
      .free_id    (wbuf_free_id),
      .cnt        (wbuf_free_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (fire) begin
         ptr_q <= (grant_idx == PtrW'(NumCh - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_bank_req_valid           <= 1'b0;
         d_bank_req_op              <= '0;
         d_bank_req_addr            <= '0;
         d_bank_req_channel_1hot_id <= '0;
         d_bank_req_wbuf_id         <= '0;
      end else if (load_en) begin
         d_bank_req_valid <= fire;
         if (fire) begin
            d_bank_req_op              <= sel_op;
            d_bank_req_addr            <= sel_addr;
            d_bank_req_channel_1hot_id <= grant;
            d_bank_req_wbuf_id         <= sel_store ? alloc_id : '0;
         end
      end
   end

endmodule
